// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding and default frame width.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_sync_edge.sv
// rxd metastability synchroniser with a registered falling-edge detector.
module uart_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_d;

  // Reset to the idle-high line level so releasing reset never fakes a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      rxd_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxd_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];
  assign fall  = rxd_d & ~rxd_s;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frames bits on clk_bps strobes and buffers one byte
// behind a valid/ready handshake.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge of rxd_s
// START | divider running, confirm start bit at first strobe
// DATA  | shift DATA_BITS data bits in, LSB first
// STOP  | sample stop bit; load buffer, flag overrun or flag framing error
// BREAK | line held low after a bad stop bit, wait for it to return high
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  input  logic                 clk_bps,
  output logic                 bps_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  rx_state_t            state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 bps_d;
  logic                 strobe;
  logic                 rxd_s;
  logic                 rxd_fall;

  uart_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .rxd  (rxd),
    .rxd_s(rxd_s),
    .fall (rxd_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bps_d <= 1'b0;
    else        bps_d <= clk_bps;
  end

  assign strobe = clk_bps & ~bps_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bps_start   <= 1'b0;
      bit_cnt     <= '0;
      shift_q     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      // A load in STOP below overrides this clear, keeping valid high with new data.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rxd_fall) begin
            state     <= START;
            bps_start <= 1'b1;
          end
        end
        START: begin
          if (strobe) begin
            if (rxd_s) begin
              state     <= IDLE;
              bps_start <= 1'b0;
            end else begin
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (strobe) begin
            shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(DATA_BITS - 1)) state <= STOP;
          end
        end
        STOP: begin
          if (strobe) begin
            bps_start <= 1'b0;
            if (rxd_s) begin
              state <= IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
              end else begin
                overrun_err <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rxd_s) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          bps_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a 16-clk-per-bit divider model and
// a byte scoreboard popped on every valid/ready handshake.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic       clk_bps;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ferr   = 0;
  int n_oerr   = 0;
  int n_valid  = 0;
  int n_rx     = 0;
  bit bps_seen = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .clk_bps    (clk_bps),
    .bps_start  (bps_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  // Baud divider model: 16-clk bits, strobe level high for the second half.
  logic [3:0] div_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         div_cnt <= '0;
    else if (!bps_start) div_cnt <= '0;
    else                div_cnt <= div_cnt + 4'd1;
  end
  assign clk_bps = bps_start && (div_cnt >= 4'd8);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (frame_err)   n_ferr++;
      if (overrun_err) n_oerr++;
      if (bps_start)   bps_seen = 1'b1;
      if (rx_valid)    n_valid++;
      if (rx_valid && rx_ready) begin
        n_rx++;
        if (exp_q.size() == 0) chk("rx_unexpected", 32'(exp_q.size()), 32'd1);
        else                   chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    bit_time(stop);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bps"},   {31'd0, bps_start},   32'd0);
    chk({tag, "_valid"}, {31'd0, rx_valid},    32'd0);
    chk({tag, "_data"},  {24'd0, rx_data},     32'd0);
    chk({tag, "_ferr"},  {31'd0, frame_err},   32'd0);
    chk({tag, "_oerr"},  {31'd0, overrun_err}, 32'd0);
  endtask

  int v0;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(5);
    chk("post_reset_idle", {31'd0, bps_start}, 32'd0);

    // Single good frame
    exp_q.push_back(8'hA5);
    bps_seen = 1'b0;
    send_frame(8'hA5, 1'b1);
    chk("byte_bps_low", {31'd0, bps_start}, 32'd0);
    chk("byte_bps_seen", {31'd0, bps_seen}, 32'd1);
    idle(8);
    chk("byte_rx_cnt", n_rx, 32'd1);
    chk("byte_ferr", n_ferr, 32'd0);
    chk("byte_oerr", n_oerr, 32'd0);

    // Glitch: false start
    bps_seen = 1'b0;
    v0 = n_valid;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    chk("glitch_bps_seen", {31'd0, bps_seen}, 32'd1);
    chk("glitch_bps_low", {31'd0, bps_start}, 32'd0);
    chk("glitch_no_valid", n_valid - v0, 32'd0);

    // Bad stop bit, then line held low
    send_frame(8'h3C, 1'b0);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    chk("break_state", 32'(dut.state), 32'(BREAK));
    chk("break_bps_low", {31'd0, bps_start}, 32'd0);
    repeat (20) @(negedge clk);
    idle(20);
    chk("badstop_ferr", n_ferr, 32'd1);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle(8);
    chk("badstop_rx_cnt", n_rx, 32'd2);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(16);
    send_frame(8'h22, 1'b1);
    idle(8);
    chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr_data_held", {24'd0, rx_data}, 32'h11);
    chk("ovr_oerr", n_oerr, 32'd1);
    chk("ovr_ferr", n_ferr, 32'd1);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovr_valid_clear", {31'd0, rx_valid}, 32'd0);
    chk("ovr_rx_cnt", n_rx, 32'd3);

    // Back-to-back with one idle bit
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    idle(16);
    send_frame(8'hFF, 1'b1);
    idle(8);
    chk("b2b_rx_cnt", n_rx, 32'd5);
    chk("b2b_ferr", n_ferr, 32'd1);
    chk("b2b_oerr", n_oerr, 32'd1);

    // Reset during data bit 4
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_in_data", 32'(dut.state), 32'(DATA));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("midrst");
    rxd = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    chk("midrst_no_frame", {31'd0, bps_start}, 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(8);
    chk("midrst_rx_cnt", n_rx, 32'd6);
    chk("midrst_ferr", n_ferr, 32'd1);
    chk("midrst_oerr", n_oerr, 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, number of rxd synchroniser flops (>=2).
REQ-003 The block SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-006 The block SHALL have port clk_bps  input  1  mid-bit sample strobe level from the baud divider; it rises at mid-bit, falls at bit end, and is held low while bps_start is low.
REQ-007 The block SHALL have port bps_start  output  1  divider enable; high for the whole frame.
REQ-008 The block SHALL have port rx_data  output  DATA_BITS  received byte held while rx_valid is high.
REQ-009 The block SHALL have port rx_valid  output  1  rx_data is valid; holds until accepted.
REQ-010 The block SHALL have port rx_ready  input  1  consumer accepts rx_data when rx_valid and rx_ready are both high.
REQ-011 The block SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 The block SHALL have port overrun_err  output  1  one-cycle pulse: good frame completed while the buffer was still full.

Function
REQ-013 The block SHALL synchronise rxd through SYNC_STAGES flops; all decisions use the synchronised value rxd_s.
REQ-014 The block SHALL detect sample strobes as clk_bps rising edges: registered previous value low, current value high.
REQ-015 The FSM states SHALL be IDLE, START, DATA, STOP, and BREAK.
REQ-016 In IDLE, a falling edge of rxd_s SHALL move the FSM to START and assert bps_start on the next cycle.
REQ-017 In START, at the first strobe: rxd_s=1 SHALL be a false start, giving bps_start low and a return to IDLE; rxd_s=0 SHALL clear the bit counter and move the FSM to DATA.
REQ-018 In DATA, each strobe SHALL shift rxd_s in LSB first; after DATA_BITS strobes the FSM SHALL move to STOP.
REQ-019 The bit counter SHALL be ceil(log2(DATA_BITS+1)) bits wide and SHALL not wrap within a frame.
REQ-020 In STOP, at the strobe with rxd_s=1: if rx_valid is low or rx_ready is high that cycle, the block SHALL load rx_data and set rx_valid the next cycle; otherwise it SHALL drop the byte, keep the old rx_data, and pulse overrun_err. Either way, bps_start SHALL go low and the FSM SHALL return to IDLE.
REQ-021 In STOP, at the strobe with rxd_s=0: the block SHALL pulse frame_err, discard the data, drive bps_start low, and move the FSM to BREAK.
REQ-022 In BREAK, the FSM SHALL stay until rxd_s=1, then return to IDLE; no frame SHALL start during BREAK.
REQ-023 bps_start SHALL be low for at least one clk cycle between frames, so the divider counter clears.
REQ-024 rx_valid SHALL clear the cycle after a rx_valid and rx_ready handshake, unless a new byte loads in that same cycle, in which case it SHALL stay high with the new data.
REQ-025 Latency: rx_valid SHALL rise 1 clk after the stop-bit strobe edge is detected.
REQ-026 rx_data and rx_valid SHALL be independent of FSM state, so the buffer survives a subsequent BREAK or false start.

Reset
REQ-027 On rst_n low, the block SHALL set: FSM=IDLE, bps_start=0, rx_valid=0, rx_data=0, frame_err=0, overrun_err=0.
REQ-028 On rst_n low, the block SHALL load the synchroniser and the clk_bps history flop with 1 and 0 respectively.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no error pulse.
REQ-030 After reset release, the block SHALL require a fresh rxd_s falling edge before starting a frame.

Structure
REQ-031 The FSM state enum and the DATA_BITS default SHALL live in shared package uart_pkg; the baud divider is instantiated outside this block.
REQ-032 One sub-module SHALL be used: uart_sync_edge, the rxd synchroniser plus falling-edge detector.

Verification
REQ-033 All scenarios SHALL use the divider with uart_ctrl=15 (16-clk bits) and rx_ready held high unless stated.
REQ-034 Scenario byte: frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> rx_valid pulse with rx_data=0xA5, no errors, and bps_start low after the stop strobe.
REQ-035 Scenario glitch: rxd low for 4 clk in IDLE -> false start, bps_start drops after the first strobe, and rx_valid stays 0.
REQ-036 Scenario bad stop: frame 0x3C with stop bit low, then rxd low for 40 clk -> one frame_err pulse, FSM in BREAK, and the next valid frame 0x55 received correctly.
REQ-037 Scenario overrun: rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x11, one overrun_err pulse; raising rx_ready then clears rx_valid.
REQ-038 Scenario back-to-back: frames 0x00 and 0xFF with a single-bit idle gap -> both received in order with no errors.
REQ-039 Scenario reset: rst_n pulsed low during DATA bit 4 -> all outputs at reset values, and a following frame 0x81 is received correctly.
